// File: rtl/gpr_scoreboard_pkg.sv
// gpr_scoreboard_pkg
//   Shared types and helpers for the GPR in-flight scoreboard.
//   - GPR_IDX_W   : architectural register index width
//   - entry_ctl_t : per-entry control fields {rd, dv}. The data field of an
//                   entry lives in a separate array in the top so that it can
//                   be left out entirely when forwarding is compiled out.
//   - ptr_full / ptr_empty : wrap-bit compare of head/tail pointers
package gpr_scoreboard_pkg;

  localparam int GPR_IDX_W = 5;

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  typedef struct packed {
    gpr_idx_t rd;
    logic     dv;
  } entry_ctl_t;

  // Indices equal and wrap bits differ: the tail has lapped the head.
  function automatic logic ptr_full(input logic idx_eq,
                                    input logic head_wrap,
                                    input logic tail_wrap);
    return idx_eq & (head_wrap ^ tail_wrap);
  endfunction

  // Indices equal and wrap bits equal: nothing in flight.
  function automatic logic ptr_empty(input logic idx_eq,
                                     input logic head_wrap,
                                     input logic tail_wrap);
    return idx_eq & ~(head_wrap ^ tail_wrap);
  endfunction

endpackage

// File: rtl/gpr_scoreboard_match.sv
// gpr_scoreboard_match
//   Combinational youngest-match selector for one decode source operand.
//   Scans backward from the entry just below the tail (with wrap-around) and
//   reports the first occupied entry whose rd equals rs. rs==0 never hits.
//   Ports:
//     valid    in  DEPTH         per-entry occupancy
//     rd       in  DEPTH x 5     per-entry destination register
//     tail_idx in  TAGW          tail index (next slot to allocate)
//     rs       in  5             queried source register
//     hit      out 1             a matching entry exists
//     sel      out TAGW          index of the youngest matching entry
module gpr_scoreboard_match
  import gpr_scoreboard_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int TAGW  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     valid,
  input  gpr_idx_t [DEPTH-1:0] rd,
  input  logic [TAGW-1:0]      tail_idx,
  input  gpr_idx_t             rs,
  output logic                 hit,
  output logic [TAGW-1:0]      sel
);

  logic [TAGW-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the untaken paths infer a latch.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    if (rs != '0) begin
      // Oldest first so that the youngest match overwrites earlier ones;
      // k==DEPTH lands on the tail slot itself (the head when full).
      for (int k = DEPTH; k >= 1; k--) begin
        idx = tail_idx - TAGW'(k);
        if (valid[idx] && (rd[idx] == rs)) begin
          hit = 1'b1;
          sel = idx;
        end
      end
    end
  end

endmodule

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard
//   In-order scoreboard of GPR writes issued past decode but not yet retired.
//   Decode queries rs1/rs2 for stall/forward decisions, execute posts results
//   by tag, writeback retires the head entry in order.
//   Build option: SCBD_FORWARD_EN enables result capture and forwarding; when
//   undefined no data array exists and any pending match stalls.
//   Ports:
//     clock, reset(sync, active-low), flush
//     issue_valid/issue_ready/issue_rd/issue_tag   allocation at the tail
//     result_valid/result_tag/result_val           early result by tag
//     retire_valid                                 retire the head entry
//     rs1/rs2 -> rsN_stall, rsN_fwd, rsN_val       operand queries
//     count, empty, full                           occupancy
module gpr_scoreboard
  import gpr_scoreboard_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int XLEN  = 32,
  localparam int TAGW  = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  gpr_idx_t        issue_rd,
  output logic [TAGW-1:0] issue_tag,
  input  logic            result_valid,
  input  logic [TAGW-1:0] result_tag,
  input  logic [XLEN-1:0] result_val,
  input  logic            retire_valid,
  input  gpr_idx_t        rs1,
  input  gpr_idx_t        rs2,
  output logic            rs1_stall,
  output logic            rs2_stall,
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [TAGW:0]   count,
  output logic            empty,
  output logic            full
);

  localparam logic [TAGW:0] PTR_ONE = 1;

  logic [TAGW:0]        head_q, tail_q;
  entry_ctl_t           ctl_q [DEPTH];
  logic [TAGW-1:0]      head_idx, tail_idx, off;
  logic                 idx_eq, issue_fire, retire_fire;
  logic [DEPTH-1:0]     occ, dv_vec;
  gpr_idx_t [DEPTH-1:0] rd_vec;
  logic                 rs1_hit, rs2_hit;
  logic [TAGW-1:0]      rs1_sel, rs2_sel;

  assign head_idx = head_q[TAGW-1:0];
  assign tail_idx = tail_q[TAGW-1:0];
  assign idx_eq   = (head_idx == tail_idx);
  assign full     = ptr_full(idx_eq, head_q[TAGW], tail_q[TAGW]);
  assign empty    = ptr_empty(idx_eq, head_q[TAGW], tail_q[TAGW]);
  assign count    = tail_q - head_q;

  // A retire in the same cycle frees the head slot, so a full buffer can
  // still accept an issue.
  assign issue_ready = ~flush & (~full | retire_valid);
  assign issue_tag   = tail_idx;
  assign issue_fire  = issue_valid & issue_ready;
  assign retire_fire = retire_valid & ~empty & ~flush;

  // Occupancy: entry i is live when its distance from the head is < count.
  always_comb begin
    occ    = '0;
    dv_vec = '0;
    rd_vec = '0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off       = TAGW'(i) - head_idx;
      occ[i]    = ({1'b0, off} < count);
      dv_vec[i] = ctl_q[i].dv;
      rd_vec[i] = ctl_q[i].rd;
    end
  end

`ifdef SCBD_FORWARD_EN
  logic            result_fire;
  logic [XLEN-1:0] data_q [DEPTH];

  assign result_fire = result_valid & ~flush & occ[result_tag];

  // NOTE: the data array has no reset; a value is only ever read behind
  // dv, which is reset, so clearing the storage would buy nothing.
  always_ff @(posedge clock) begin
    if (result_fire) data_q[result_tag] <= result_val;
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every read in
  // this block sees pre-edge values and the later issue write to a slot
  // takes precedence over an earlier result write to the same slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) ctl_q[i] <= '0;
    end else if (flush) begin
      head_q <= tail_q;
      for (int i = 0; i < DEPTH; i++) ctl_q[i].dv <= 1'b0;
    end else begin
      if (retire_fire) head_q <= head_q + PTR_ONE;
`ifdef SCBD_FORWARD_EN
      if (result_fire) ctl_q[result_tag].dv <= 1'b1;
`endif
      if (issue_fire) begin
        ctl_q[tail_idx] <= '{rd: issue_rd, dv: 1'b0};
        tail_q          <= tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(retire_valid && empty && !flush));
`ifdef SCBD_FORWARD_EN
      assert (!(result_valid && !occ[result_tag]));
`endif
    end
  end

  gpr_scoreboard_match #(.DEPTH(DEPTH)) u_match_rs1 (
    .valid(occ), .rd(rd_vec), .tail_idx(tail_idx), .rs(rs1),
    .hit(rs1_hit), .sel(rs1_sel)
  );

  gpr_scoreboard_match #(.DEPTH(DEPTH)) u_match_rs2 (
    .valid(occ), .rd(rd_vec), .tail_idx(tail_idx), .rs(rs2),
    .hit(rs2_hit), .sel(rs2_sel)
  );

`ifdef SCBD_FORWARD_EN
  assign rs1_fwd   = rs1_hit & dv_vec[rs1_sel];
  assign rs1_stall = rs1_hit & ~dv_vec[rs1_sel];
  assign rs1_val   = rs1_fwd ? data_q[rs1_sel] : '0;
  assign rs2_fwd   = rs2_hit & dv_vec[rs2_sel];
  assign rs2_stall = rs2_hit & ~dv_vec[rs2_sel];
  assign rs2_val   = rs2_fwd ? data_q[rs2_sel] : '0;
`else
  // Without a data array any in-flight writer of the operand blocks decode.
  logic unused_ok;
  assign unused_ok = ^{result_valid, result_tag, result_val, dv_vec,
                       rs1_sel, rs2_sel};
  assign rs1_stall = rs1_hit;
  assign rs2_stall = rs2_hit;
  assign rs1_fwd   = 1'b0;
  assign rs2_fwd   = 1'b0;
  assign rs1_val   = '0;
  assign rs2_val   = '0;
`endif

endmodule

// File: tb/tb_gpr_scoreboard.sv
// tb_gpr_scoreboard
//   Directed bench for gpr_scoreboard (DEPTH=4, XLEN=32). Each step drives
//   inputs, queues the expected outputs for that cycle, then compares them
//   on the falling edge before the state-changing rising edge.
module tb_gpr_scoreboard;

`ifdef SCBD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock, reset, flush;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_tag;
  logic        result_valid;
  logic [1:0]  result_tag;
  logic [31:0] result_val;
  logic        retire_valid;
  logic [4:0]  rs1, rs2;
  logic        rs1_stall, rs2_stall, rs1_fwd, rs2_fwd;
  logic [31:0] rs1_val, rs2_val;
  logic [2:0]  count;
  logic        empty, full;

  gpr_scoreboard #(.DEPTH(4), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_tag(issue_tag),
    .result_valid(result_valid), .result_tag(result_tag),
    .result_val(result_val), .retire_valid(retire_valid),
    .rs1(rs1), .rs2(rs2),
    .rs1_stall(rs1_stall), .rs2_stall(rs2_stall),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .count(count), .empty(empty), .full(full)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef enum int {
    S_COUNT, S_EMPTY, S_FULL, S_READY, S_TAG,
    S_RS1_STALL, S_RS1_FWD, S_RS1_VAL,
    S_RS2_STALL, S_RS2_FWD, S_RS2_VAL
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_COUNT:     return 32'(count);
      S_EMPTY:     return 32'(empty);
      S_FULL:      return 32'(full);
      S_READY:     return 32'(issue_ready);
      S_TAG:       return 32'(issue_tag);
      S_RS1_STALL: return 32'(rs1_stall);
      S_RS1_FWD:   return 32'(rs1_fwd);
      S_RS1_VAL:   return rs1_val;
      S_RS2_STALL: return 32'(rs2_stall);
      S_RS2_FWD:   return 32'(rs2_fwd);
      S_RS2_VAL:   return rs2_val;
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic want(input sig_e s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.val = v;
    expq.push_back(e);
  endtask

  task automatic want_q1(input logic st, input logic fw, input logic [31:0] v);
    want(S_RS1_STALL, 32'(st));
    want(S_RS1_FWD,   32'(fw));
    want(S_RS1_VAL,   v);
  endtask

  task automatic want_q2(input logic st, input logic fw, input logic [31:0] v);
    want(S_RS2_STALL, 32'(st));
    want(S_RS2_FWD,   32'(fw));
    want(S_RS2_VAL,   v);
  endtask

  task automatic check(input sig_e s, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL step%0d %s: observed=%0h expected=%0h", step, s.name(), obs, exp);
    end
  endtask

  // Pop every expectation queued for this cycle and compare on the falling edge.
  task automatic drain();
    exp_t e;
    @(negedge clock);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      check(e.sig, observe(e.sig), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    issue_valid  = 1'b0;
    result_valid = 1'b0;
    retire_valid = 1'b0;
    flush        = 1'b0;
    step++;
  endtask

  task automatic post(input logic [1:0] tag, input logic [31:0] v);
    result_valid = 1'b1;
    result_tag   = tag;
    result_val   = v;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  logic [4:0] fill_rd [4];

  initial begin
    reset = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    result_valid = 1'b0; result_tag = '0; result_val = '0;
    retire_valid = 1'b0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Post-reset state
    rs1 = 5;
    want(S_COUNT, 0); want(S_EMPTY, 1); want(S_FULL, 0);
    want(S_READY, 1); want(S_TAG, 0); want_q1(0, 0, 0);
    drain(); tick();

    // Issue rd=5 at tag 0
    issue(5);
    want(S_READY, 1); want(S_TAG, 0);
    drain(); tick();

    // Pending with no data; result posted this cycle is not yet visible
    rs1 = 5; post(0, 32'h1234);
    want(S_COUNT, 1); want(S_EMPTY, 0); want_q1(1, 0, 0);
    drain(); tick();

    // Result visible; retiring entry still serves the query
    rs1 = 5; retire_valid = 1'b1;
    want_q1(!FWD, FWD, FWD ? 32'h1234 : 32'h0);
    drain(); tick();

    // Retired: no match
    want(S_COUNT, 0); want(S_EMPTY, 1); want(S_TAG, 1); want_q1(0, 0, 0);
    drain(); tick();

    // Two writers of rd=7; only the older one gets data
    issue(7);
    want(S_TAG, 1);
    drain(); tick();
    issue(7); post(1, 32'hAA);
    want(S_TAG, 2);
    drain(); tick();

    rs1 = 9; rs2 = 7; post(2, 32'hBB);
    want(S_COUNT, 2); want_q2(1, 0, 0); want_q1(0, 0, 0);
    drain(); tick();

    rs2 = 7;
    want_q2(!FWD, FWD, FWD ? 32'hBB : 32'h0);
    drain(); tick();

    // Retire both, the youngest remains visible until its own retire edge
    retire_valid = 1'b1;
    want_q2(!FWD, FWD, FWD ? 32'hBB : 32'h0);
    drain(); tick();
    retire_valid = 1'b1;
    want_q2(!FWD, FWD, FWD ? 32'hBB : 32'h0);
    drain(); tick();

    want(S_COUNT, 0); want(S_TAG, 3); want_q2(0, 0, 0);
    drain(); tick();

    // Fill all four slots, wrapping the tail index
    fill_rd[0] = 2; fill_rd[1] = 4; fill_rd[2] = 2; fill_rd[3] = 6;
    for (int k = 0; k < 4; k++) begin
      issue(fill_rd[k]);
      want(S_READY, 1); want(S_COUNT, 32'(k)); want(S_TAG, 32'((3 + k) % 4));
      drain(); tick();
    end

    // Full: issue without retire is refused; data lands on the oldest rd=2
    issue(8); rs1 = 2; post(3, 32'h33);
    want(S_FULL, 1); want(S_COUNT, 4); want(S_READY, 0); want_q1(1, 0, 0);
    drain(); tick();

    // Youngest rd=2 (tag1) has no data, so the older forwardable one is ignored
    rs1 = 2; rs2 = 6;
    want(S_COUNT, 4); want_q1(1, 0, 0); want_q2(1, 0, 0);
    drain(); tick();

    // Issue and retire together while full
    issue(8); retire_valid = 1'b1;
    want(S_READY, 1); want(S_TAG, 3); want(S_COUNT, 4); want(S_FULL, 1);
    drain(); tick();

    rs1 = 2; rs2 = 8; post(1, 32'h22);
    want(S_COUNT, 4); want(S_FULL, 1); want_q1(1, 0, 0); want_q2(1, 0, 0);
    drain(); tick();

    // Wrapped scan finds tag1 for rd=2; retiring tag0 (rd=4) still stalls rs2
    rs1 = 2; rs2 = 4; retire_valid = 1'b1;
    want_q1(!FWD, FWD, FWD ? 32'h22 : 32'h0); want_q2(1, 0, 0);
    drain(); tick();

    // Flush with issue in the same cycle
    flush = 1'b1; issue(9);
    want(S_READY, 0); want(S_COUNT, 3);
    drain(); tick();

    rs1 = 2; rs2 = 9;
    want(S_COUNT, 0); want(S_EMPTY, 1); want(S_FULL, 0); want(S_READY, 1);
    want(S_TAG, 0); want_q1(0, 0, 0); want_q2(0, 0, 0);
    drain(); tick();

    // rd=0 allocates but never matches
    issue(0);
    want(S_TAG, 0);
    drain(); tick();
    rs1 = 0; rs2 = 0; post(0, 32'h55);
    want(S_COUNT, 1); want_q1(0, 0, 0); want_q2(0, 0, 0);
    drain(); tick();
    retire_valid = 1'b1;
    want_q1(0, 0, 0);
    drain(); tick();

    want(S_COUNT, 0); want(S_EMPTY, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_scoreboard.md
Name: gpr_scoreboard

Overview:
- In-order scoreboard tracking GPR writes that have been issued downstream of decode but not yet retired at writeback.
- Decode queries it with rs1/rs2 to get per-operand stall and forward decisions; execute posts early results by tag; writeback retires entries in order.
- Replaces the single-stage EXU bypass compare with a DEPTH-entry in-flight window, so decode can issue past multi-cycle LSU/MUL ops safely.

Parameters:
- DEPTH, 4, number of in-flight entries; power of two, ≥2.
- XLEN, 32, GPR data width.
- TAGW, $clog2(DEPTH), entry tag width (derived, not overridable).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush; discards all entries
- issue_valid  in  1  decode issues an instruction
- issue_ready  out  1  entry available
- issue_rd  in  5  destination register; 0 = no GPR write
- issue_tag  out  TAGW  tag allocated to the issuing instruction (tail index)
- result_valid  in  1  execute posts a result
- result_tag  in  TAGW  entry receiving the result
- result_val  in  XLEN  result value
- retire_valid  in  1  writeback retires the head entry (GPR written this edge)
- rs1, rs2  in  5  decode source registers
- rs1_stall, rs2_stall  out  1  operand pending and no value available
- rs1_fwd, rs2_fwd  out  1  forward value is valid and must replace the regfile read
- rs1_val, rs2_val  out  XLEN  forwarded value
- count  out  TAGW+1  occupied entries
- empty, full  out  1  count==0 / count==DEPTH

Behaviour:
- Storage: circular buffer. Each entry holds rd[4:0], dv (data valid) and data[XLEN-1:0]. head/tail pointers are TAGW+1 bits; the extra bit is the wrap bit. full when the indices are equal and the wrap bits differ.
- Reset (reset==0 at clock edge):
  - head=tail=0, all dv=0.
  - Outputs: count=0, empty=1, full=0, issue_ready=1, all stall/fwd=0, vals=0.
- Issue handshake:
  - issue_ready = ~flush & (~full | retire_valid).
  - When issue_valid & issue_ready: the entry at tail gets rd=issue_rd, dv=0; tail increments.
  - issue_tag = tail index, combinational.
  - rd=0 still allocates an entry, which preserves retire order.
- Result: when result_valid, the entry at result_tag is set dv=1 and data=result_val at the edge.
  - The result is visible to queries from the next cycle; there is no same-cycle result bypass.
  - A result to an unoccupied tag is ignored (simulation assertion).
- Retire: when retire_valid & ~empty, head increments. Retire on empty is ignored (assertion).
- Simultaneous issue and retire when full: both happen; count is unchanged.
- Flush: head<=tail (buffer emptied), all dv<=0.
  - Flush wins over issue in the same cycle; issue_ready=0 during flush.
  - A retire in the same cycle is absorbed.
  - A result in the same cycle is dropped.
- Query (combinational, rsN ∈ {rs1, rs2}):
  - match = valid entry with rd==rsN and rsN!=0.
  - Select the YOUNGEST match: nearest to tail, scanning backward, with wrap-around.
  - No match: stall=0, fwd=0, val=0.
  - Youngest match with dv=1: stall=0, fwd=1, val=data.
  - Youngest match with dv=0: stall=1, fwd=0.
  - Queries use pre-edge state. An entry retiring this cycle is still visible, so a query in that cycle is served by it (forward or stall), never by the stale regfile.
- Latency: issue→visible next cycle; result→forwardable next cycle; retire→entry gone next cycle.

Optional Feature:
- SCBD_FORWARD_EN defined: forwarding exactly as in Behaviour.
- SCBD_FORWARD_EN undefined:
  - The data array is not instantiated; result_* inputs are unused.
  - rsN_fwd=0 and rsN_val=0 always.
  - rsN_stall=1 whenever any valid entry matches rsN (rsN!=0).

Decomposition:
- Shared package gpr_scoreboard_pkg:
  - GPR index width constant (5).
  - Entry struct typedef {rd, dv, data}.
  - Helper function for the pointer wrap-bit full/empty compare.
- Sub-module gpr_scoreboard_match: combinational youngest-match priority selector.
  - Inputs: per-entry valid vector, rd array, tail index, query rs.
  - Outputs: hit and selected index.
  - Instantiated once per query port.

Test Plan:
- Reset, then query rs1=5 → empty=1, count=0, issue_ready=1, rs1_stall=0, rs1_fwd=0.
- Issue rd=5 (tag 0); next cycle query rs1=5 → rs1_stall=1. Post result tag0=0x1234; next cycle → rs1_fwd=1, rs1_val=0x1234, stall=0 (FORWARD_EN).
- Issue rd=7 twice (tags 0,1); post result 0xAA to tag0 only; query rs2=7 → youngest (tag1, dv=0) wins, rs2_stall=1. Post tag1=0xBB → rs2_val=0xBB.
- Fill DEPTH=4 entries → full=1. Assert issue with no retire → issue_ready=0. Assert issue and retire together → accepted, count stays 4. Wrap-around query still finds the youngest match.
- Three entries pending, assert flush together with issue_valid → next cycle count=0, empty=1, the issue was not allocated, and queries return no match.
- Issue rd=0, then query rs1=0 → stall=0, fwd=0. Build without SCBD_FORWARD_EN: issue rd=3, post result, query rs1=3 → rs1_stall=1 until retire, then 0.
